// File: rtl/reg_bank_demux8x32_pkg.sv
// Shared definitions for the reg_bank_demux8x32 write-side register bank.
//   ENTRIES / ADDR_W : bank geometry (fixed at 8 entries, 3-bit index)
//   strb_w()         : byte-enable width for a given data width
//   state_t          : bank control state (IDLE accepts writes, CLEAR wipes the bank)
package reg_bank_demux8x32_pkg;

    localparam int ENTRIES = 8;
    localparam int ADDR_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int strb_w(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/reg_bank_demux8x32_byte_merge32.sv
// Combinational byte merge: each byte of merged comes from new_word where the
// matching strb bit is set, otherwise from old_word.
//   old_word  in   WIDTH      current contents
//   new_word  in   WIDTH      incoming write data
//   strb      in   WIDTH/8    byte enables
//   merged    out  WIDTH      merged word
module byte_merge32
    import reg_bank_demux8x32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         old_word,
    input  logic [WIDTH-1:0]         new_word,
    input  logic [strb_w(WIDTH)-1:0] strb,
    output logic [WIDTH-1:0]         merged
);

    for (genvar k = 0; k < strb_w(WIDTH); k++) begin : g_byte
        assign merged[8*k +: 8] = strb[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end

endmodule

// File: rtl/reg_bank_demux8x32.sv
// Eight-entry write-side register bank with byte-masked writes over a
// valid/ready handshake and a sequenced bulk clear (one entry per cycle).
//   clk, rst        clock, synchronous active-high reset
//   wr_valid/ready  write handshake; ready only while IDLE
//   wr_addr/data/strb  target entry, data, byte enables
//   clr_req         start bulk clear (ignored while clearing)
//   busy            bulk clear in progress
//   valid_mask      bit n set once entry n is written, cleared by clear/reset
//   o0..o7          registered contents of entries 0..7
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting writes; clr_req starts a clear
// CLEAR | zeroing entry[cnt] each cycle, cnt 0..7; writes backpressured
module reg_bank_demux8x32
    import reg_bank_demux8x32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [strb_w(WIDTH)-1:0] wr_strb,
    input  logic                     clr_req,
    output logic                     busy,
    output logic [ENTRIES-1:0]       valid_mask,
    output logic [WIDTH-1:0]         o0,
    output logic [WIDTH-1:0]         o1,
    output logic [WIDTH-1:0]         o2,
    output logic [WIDTH-1:0]         o3,
    output logic [WIDTH-1:0]         o4,
    output logic [WIDTH-1:0]         o5,
    output logic [WIDTH-1:0]         o6,
    output logic [WIDTH-1:0]         o7
);

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [WIDTH-1:0]    entry [ENTRIES];
    logic [WIDTH-1:0]    merged;
    logic [ENTRIES-1:0]  wr_sel;
    logic                wr_fire;

    assign wr_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_sel   = ENTRIES'(1) << wr_addr;

    // Single merge unit; its result is steered to the addressed entry below.
    byte_merge32 #(.WIDTH(WIDTH)) u_merge (
        .old_word (entry[wr_addr]),
        .new_word (wr_data),
        .strb     (wr_strb),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            valid_mask <= '0;
            for (int i = 0; i < ENTRIES; i++) entry[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_fire) begin
                        for (int i = 0; i < ENTRIES; i++) begin
                            if (wr_sel[i]) begin
                                entry[i]      <= merged;
                                valid_mask[i] <= 1'b1;
                            end
                        end
                    end
                    // A same-edge write still commits; the clear reaches it later.
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    entry[cnt]      <= '0;
                    valid_mask[cnt] <= 1'b0;
                    if (cnt == ADDR_W'(ENTRIES - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign o0 = entry[0];
    assign o1 = entry[1];
    assign o2 = entry[2];
    assign o3 = entry[3];
    assign o4 = entry[4];
    assign o5 = entry[5];
    assign o6 = entry[6];
    assign o7 = entry[7];

endmodule

// File: tb/tb_reg_bank_demux8x32.sv
module tb_reg_bank_demux8x32;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        clr_req;
    logic        busy;
    logic [7:0]  valid_mask;
    logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [31:0] o_arr [8];

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    reg_bank_demux8x32 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .clr_req(clr_req), .busy(busy), .valid_mask(valid_mask),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7)
    );

    assign o_arr[0] = o0; assign o_arr[1] = o1; assign o_arr[2] = o2; assign o_arr[3] = o3;
    assign o_arr[4] = o4; assign o_arr[5] = o5; assign o_arr[6] = o6; assign o_arr[7] = o7;

    // Behavioural model: bank contents, written flags, and clear progress.
    logic [31:0] m_entry [8];
    logic [7:0]  m_mask;
    bit          m_clearing;
    int          m_pos;

    function automatic logic [31:0] m_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_entry[i] <= 32'h0;
            m_mask     <= 8'h00;
            m_clearing <= 1'b0;
            m_pos      <= 0;
        end else if (!m_clearing) begin
            if (wr_valid) begin
                m_entry[wr_addr] <= m_merge(m_entry[wr_addr], wr_data, wr_strb);
                m_mask[wr_addr]  <= 1'b1;
            end
            if (clr_req) begin
                m_clearing <= 1'b1;
                m_pos      <= 0;
            end
        end else begin
            m_entry[m_pos] <= 32'h0;
            m_mask[m_pos]  <= 1'b0;
            if (m_pos == 7) begin
                m_clearing <= 1'b0;
                m_pos      <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 8; i++) check($sformatf("model_o%0d", i), o_arr[i], m_entry[i]);
            check("model_mask", {24'h0, valid_mask}, {24'h0, m_mask});
            check("model_busy", {31'h0, busy}, {31'h0, m_clearing});
            check("model_ready", {31'h0, wr_ready}, {31'h0, !m_clearing});
        end
    end

    task automatic put(input logic v, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic c);
        wr_valid = v; wr_addr = a; wr_data = d; wr_strb = s; clr_req = c;
    endtask

    int n;

    initial begin
        rst = 1'b1;
        put(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        started = 1'b1;
        // 1: reset state
        for (int i = 0; i < 8; i++) check($sformatf("reset_o%0d", i), o_arr[i], 32'h0);
        check("reset_mask", {24'h0, valid_mask}, 32'h0);
        check("reset_ready", {31'h0, wr_ready}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);

        // 2: full write
        put(1'b1, 3'd5, 32'hDEADBEEF, 4'hF, 1'b0);
        @(negedge clk);
        put(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
        check("t2_o5", o5, 32'hDEADBEEF);
        check("t2_mask", {24'h0, valid_mask}, 32'h20);
        check("t2_o4", o4, 32'h0);

        // 3: partial write, then strobe-less write
        put(1'b1, 3'd5, 32'h11223344, 4'b0101, 1'b0);
        @(negedge clk);
        check("t3_o5", o5, 32'hDE22BE44);
        put(1'b1, 3'd2, 32'hFFFFFFFF, 4'h0, 1'b0);
        @(negedge clk);
        put(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
        check("t3_o2", o2, 32'h0);
        check("t3_mask", {24'h0, valid_mask}, 32'h24);

        // 4: fill, clear with writer held, clr_req repeated mid-clear
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 3'(i), 32'h01010101 * (i + 1), 4'hF, 1'b0);
            @(negedge clk);
        end
        check("t4_full_mask", {24'h0, valid_mask}, 32'hFF);
        check("t4_o6", o6, 32'h07070707);
        put(1'b1, 3'd3, 32'hCAFEF00D, 4'hF, 1'b1);
        @(negedge clk);
        check("t4_o3_sameedge", o3, 32'hCAFEF00D);
        n = 0;
        while (busy && n < 20) begin
            n++;
            clr_req = (n == 3);
            wr_addr = 3'(n % 8);
            @(negedge clk);
        end
        put(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
        check("t4_busy_cycles", n, 8);
        check("t4_mask_end", {24'h0, valid_mask}, 32'h0);
        check("t4_o7_end", o7, 32'h0);

        // 5: same-edge write and clear of entry 0
        put(1'b1, 3'd0, 32'hA5A5A5A5, 4'hF, 1'b1);
        @(negedge clk);
        put(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
        check("t5_o0_first", o0, 32'hA5A5A5A5);
        @(negedge clk);
        check("t5_o0_second", o0, 32'h0);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t5_busy_drop", {31'h0, busy}, 32'h0);

        // 6: reset during 4th clear cycle
        put(1'b1, 3'd6, 32'h66666666, 4'hF, 1'b0);
        @(negedge clk);
        put(1'b1, 3'd7, 32'h77777777, 4'hF, 1'b0);
        @(negedge clk);
        put(1'b0, 3'd0, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy_before", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_ready", {31'h0, wr_ready}, 32'h1);
        check("t6_o7", o7, 32'h0);
        check("t6_mask", {24'h0, valid_mask}, 32'h0);
        put(1'b1, 3'd4, 32'h12345678, 4'hF, 1'b0);
        @(negedge clk);
        put(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
        check("t6_o4", o4, 32'h12345678);
        check("t6_mask_after", {24'h0, valid_mask}, 32'h10);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
